// File: rtl/mon_scan_sequencer.sv
// mon_scan_sequencer: autonomous channel scan controller for the monitoring ADC.
// Walks a latched channel mask, drives the one-hot analog MUX select, settles,
// runs 1/2/4/8 conversions per enabled channel and emits one averaged result each.
//
// Ports:
//    clk40        40 MHz clock, rising edge
//    rst_b        asynchronous active-low reset
//    scan_start   single-cycle start request, honoured only when idle
//    scan_mask    per-channel enable, latched at start
//    settle_cyc   MUX settling cycles before the first conversion of a channel
//    avg_log2     log2 of conversions averaged per channel
//    mon_vin_sel  one-hot MUX select, zero when not converting
//    adc_soc      one-cycle start-of-conversion pulse
//    adc_eoc_b    ADC end-of-conversion, active-low
//    adc_out      ADC result, valid while adc_eoc_b is low
//    res_valid    one-cycle result strobe
//    res_ch       channel index of the last result
//    res_data     averaged result of the last emitted channel
//    scan_busy    scan in progress
//    scan_done    one-cycle end-of-scan pulse
//    timeout_err  sticky conversion timeout flag, cleared by an accepted start
module mon_scan_sequencer #(
   parameter int NCH     = 40,
   parameter int TIMEOUT = 255
) (
   input  logic           clk40,
   input  logic           rst_b,
   input  logic           scan_start,
   input  logic [NCH-1:0] scan_mask,
   input  logic [7:0]     settle_cyc,
   input  logic [1:0]     avg_log2,
   output logic [NCH-1:0] mon_vin_sel,
   output logic           adc_soc,
   input  logic           adc_eoc_b,
   input  logic [11:0]    adc_out,
   output logic           res_valid,
   output logic [5:0]     res_ch,
   output logic [11:0]    res_data,
   output logic           scan_busy,
   output logic           scan_done,
   output logic           timeout_err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, FIND, SETTLE, SOC, WAIT_EOC, EMIT, NEXT, DONE_P} state_t;

   state_t         state, state_nx;
   logic [NCH-1:0] mask_q;
   logic [7:0]     settle_q;
   logic [1:0]     avg_q;
   logic [5:0]     ch;
   logic [7:0]     settle_cnt;
   logic [TW-1:0]  tcnt;
   logic [14:0]    acc;
   logic [3:0]     cnt;
   logic           eoc_q;
   logic           eoc_p;

   logic           last_ch;
   logic           eoc_fall;
   logic           timed_out;
   logic [14:0]    sum;
   logic [3:0]     cnt_nx;
   logic           avg_done;
   logic           sel_hold;
   logic [NCH-1:0] one_hot;

   assign last_ch   = ch == 6'(NCH - 1);
   assign eoc_fall  = eoc_p & ~eoc_q;
   assign timed_out = tcnt == TW'(TIMEOUT - 1);
   assign sum       = acc + 15'(adc_out);
   assign cnt_nx    = cnt + 4'd1;
   assign avg_done  = cnt_nx == (4'd1 << avg_q);
   assign one_hot   = {{(NCH-1){1'b0}}, 1'b1} << ch;
   // The select is held from the first settle cycle through the result strobe;
   // it drops in NEXT so consecutive channels never overlap on the MUX.
   assign sel_hold  = state_nx inside {SETTLE, SOC, WAIT_EOC, EMIT};

   always_ff @(posedge clk40 or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      adc_soc   = 1'b0;
      res_valid = 1'b0;
      scan_done = 1'b0;
      scan_busy = 1'b1;
      case (state)
         IDLE: begin
            scan_busy = 1'b0;
            if (scan_start) state_nx = FIND;
         end
         FIND:     state_nx = mask_q[ch] ? SETTLE : (last_ch ? DONE_P : FIND);
         SETTLE:   state_nx = (settle_cnt == 8'd0) ? SOC : SETTLE;
         SOC: begin
            adc_soc  = 1'b1;
            state_nx = WAIT_EOC;
         end
         WAIT_EOC: state_nx = eoc_fall ? (avg_done ? EMIT : SOC) : (timed_out ? NEXT : WAIT_EOC);
         EMIT: begin
            res_valid = 1'b1;
            state_nx  = NEXT;
         end
         NEXT:     state_nx = last_ch ? DONE_P : FIND;
         DONE_P: begin
            scan_busy = 1'b0;
            scan_done = 1'b1;
            state_nx  = IDLE;
         end
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk40 or negedge rst_b) begin
      if (!rst_b) begin
         mask_q      <= '0;
         settle_q    <= '0;
         avg_q       <= '0;
         ch          <= '0;
         settle_cnt  <= '0;
         tcnt        <= '0;
         acc         <= '0;
         cnt         <= '0;
         eoc_q       <= 1'b0;
         eoc_p       <= 1'b0;
         mon_vin_sel <= '0;
         res_ch      <= '0;
         res_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         eoc_q       <= adc_eoc_b;
         // Forcing the previous sample low across SOC means a level that is
         // already low when WAIT_EOC starts can never look like a falling edge.
         eoc_p       <= (state == SOC) ? 1'b0 : eoc_q;
         mon_vin_sel <= sel_hold ? one_hot : '0;
         case (state)
            IDLE: begin
               if (scan_start) begin
                  mask_q      <= scan_mask;
                  settle_q    <= settle_cyc;
                  avg_q       <= avg_log2;
                  timeout_err <= 1'b0;
                  ch          <= '0;
               end
            end
            FIND: begin
               if (mask_q[ch]) begin
                  settle_cnt <= settle_q;
                  acc        <= '0;
                  cnt        <= '0;
               end else if (!last_ch) begin
                  ch <= ch + 6'd1;
               end
            end
            SETTLE: settle_cnt <= settle_cnt - 8'd1;
            SOC:    tcnt <= '0;
            WAIT_EOC: begin
               tcnt <= tcnt + TW'(1);
               if (eoc_fall) begin
                  acc <= sum;
                  cnt <= cnt_nx;
                  if (avg_done) begin
                     res_ch   <= ch;
                     res_data <= 12'(sum >> avg_q);
                  end
               end else if (timed_out) begin
                  timeout_err <= 1'b1;
                  acc         <= '0;
                  cnt         <= '0;
               end
            end
            NEXT: if (!last_ch) ch <= ch + 6'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mon_scan_sequencer.sv
// tb_mon_scan_sequencer: directed scoreboard bench for mon_scan_sequencer.
module tb_mon_scan_sequencer;

   localparam int NCH     = 40;
   localparam int TIMEOUT = 255;

   logic           clk40 = 1'b0;
   logic           rst_b = 1'b0;
   logic           scan_start = 1'b0;
   logic [NCH-1:0] scan_mask = '0;
   logic [7:0]     settle_cyc = '0;
   logic [1:0]     avg_log2 = '0;
   logic [NCH-1:0] mon_vin_sel;
   logic           adc_soc;
   logic           adc_eoc_b = 1'b1;
   logic [11:0]    adc_out = '0;
   logic           res_valid;
   logic [5:0]     res_ch;
   logic [11:0]    res_data;
   logic           scan_busy;
   logic           scan_done;
   logic           timeout_err;

   mon_scan_sequencer #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
      .clk40(clk40), .rst_b(rst_b), .scan_start(scan_start), .scan_mask(scan_mask),
      .settle_cyc(settle_cyc), .avg_log2(avg_log2), .mon_vin_sel(mon_vin_sel),
      .adc_soc(adc_soc), .adc_eoc_b(adc_eoc_b), .adc_out(adc_out), .res_valid(res_valid),
      .res_ch(res_ch), .res_data(res_data), .scan_busy(scan_busy), .scan_done(scan_done),
      .timeout_err(timeout_err)
   );

   always #5 clk40 = ~clk40;

   int total = 0;
   int bad = 0;
   logic [17:0] sb[$];
   logic [11:0] samples[$];
   int lat = 20;
   int adc_wait = -1;
   int low_left = 0;
   int sidx = 0;
   logic mute_en = 1'b0;
   int mute_ch = 0;
   int soc_cnt = 0;
   int res_cnt = 0;
   int done_cnt = 0;
   int sel_cycles = 0;
   logic soc_prev = 1'b0;
   logic [62:0] outs;

   assign outs = {mon_vin_sel, adc_soc, res_valid, res_ch, res_data, scan_busy, scan_done, timeout_err};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ADC model: EOC_B falls lat cycles after a SOC and stays low two cycles.
   always @(negedge clk40) begin
      if (low_left > 0) begin
         low_left--;
         if (low_left == 0) adc_eoc_b = 1'b1;
      end
      if (adc_wait > 0) adc_wait--;
      else if (adc_wait == 0) begin
         adc_eoc_b = 1'b0;
         adc_out   = samples[sidx % samples.size()];
         sidx++;
         low_left  = 2;
         adc_wait  = -1;
      end
      if (adc_soc && !(mute_en && mon_vin_sel[mute_ch])) adc_wait = lat - 1;
   end

   // Output monitor: scoreboard pops and invariants.
   always @(negedge clk40) begin
      logic [17:0] exp;
      if (adc_soc) begin
         soc_cnt++;
         check("soc_width", 64'(soc_prev), 64'(0));
         check("soc_with_sel", 64'(mon_vin_sel != '0), 64'(1));
      end
      soc_prev = adc_soc;
      if (mon_vin_sel != '0) begin
         sel_cycles++;
         check("sel_onehot", 64'($onehot(mon_vin_sel)), 64'(1));
      end
      if (scan_done) done_cnt++;
      if (res_valid) begin
         res_cnt++;
         check("res_done_overlap", 64'(scan_done), 64'(0));
         exp = (sb.size() != 0) ? sb.pop_front() : 18'h3FFFF;
         check("result", 64'({res_ch, res_data}), 64'(exp));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk40);
   endtask

   task automatic start_scan(input logic [NCH-1:0] m, input logic [7:0] s, input logic [1:0] a);
      tick(1);
      scan_mask  = m;
      settle_cyc = s;
      avg_log2   = a;
      scan_start = 1'b1;
      tick(1);
      scan_start = 1'b0;
      scan_mask  = ~m;
      settle_cyc = 8'hFF;
      avg_log2   = ~a;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 1;
      while (!scan_done && n < budget) begin
         tick(1);
         n++;
      end
      check("done_seen", 64'(scan_done), 64'(1));
   endtask

   task automatic wait_soc(input int budget);
      int n = 0;
      while (!adc_soc && n < budget) begin
         tick(1);
         n++;
      end
      check("soc_seen", 64'(adc_soc), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, s0, r0, d0, c0;
      tick(2);
      check("reset_outputs", 64'(outs), 64'(0));
      rst_b = 1'b1;
      tick(2);
      check("idle_outputs", 64'(outs), 64'(0));

      // single channel, settle 3, no averaging
      samples = '{12'hABC};
      lat = 20;
      s0 = soc_cnt; r0 = res_cnt;
      sb.push_back({6'd0, 12'hABC});
      start_scan(40'h1, 8'd3, 2'd0);
      check("t1_busy", 64'(scan_busy), 64'(1));
      n = 0;
      while (mon_vin_sel == '0 && n < 50) begin tick(1); n++; end
      check("t1_sel", 64'(mon_vin_sel), 64'(1));
      n = 0;
      while (!adc_soc && n < 50) begin n++; tick(1); end
      check("t1_settle_cycles", 64'(n), 64'(4));
      wait_done(200, n);
      check("t1_done_busy", 64'(scan_busy), 64'(0));
      check("t1_soc_count", 64'(soc_cnt - s0), 64'(1));
      check("t1_res_count", 64'(res_cnt - r0), 64'(1));
      check("t1_sb_empty", 64'(sb.size()), 64'(0));
      tick(3);
      check("t1_hold", 64'({res_ch, res_data}), 64'({6'd0, 12'hABC}));

      // two channels, average of four
      samples = '{12'd100, 12'd101, 12'd102, 12'd104};
      s0 = soc_cnt; r0 = res_cnt;
      sb.push_back({6'd5, 12'd101});
      sb.push_back({6'd39, 12'd101});
      start_scan(40'h80_0000_0020, 8'd2, 2'd2);
      wait_done(1000, n);
      check("t2_soc_count", 64'(soc_cnt - s0), 64'(8));
      check("t2_res_count", 64'(res_cnt - r0), 64'(2));
      check("t2_sb_empty_at_done", 64'(sb.size()), 64'(0));

      // empty mask
      s0 = soc_cnt; r0 = res_cnt; c0 = sel_cycles;
      start_scan('0, 8'd5, 2'd1);
      wait_done(100, n);
      check("t3_done_latency", 64'(n), 64'(41));
      check("t3_soc_count", 64'(soc_cnt - s0), 64'(0));
      check("t3_res_count", 64'(res_cnt - r0), 64'(0));
      check("t3_sel_cycles", 64'(sel_cycles - c0), 64'(0));

      // channel 2 never answers
      samples = '{12'h123};
      lat = 10;
      mute_en = 1'b1;
      mute_ch = 2;
      r0 = res_cnt;
      sb.push_back({6'd3, 12'h123});
      start_scan(40'hC, 8'd2, 2'd0);
      wait_soc(100);
      check("t4_soc_ch2", 64'(mon_vin_sel), 64'(40'h4));
      tick(TIMEOUT - 1);
      check("t4_err_early", 64'(timeout_err), 64'(0));
      tick(2);
      check("t4_err_set", 64'(timeout_err), 64'(1));
      wait_done(400, n);
      mute_en = 1'b0;
      check("t4_res_count", 64'(res_cnt - r0), 64'(1));
      check("t4_sb_empty", 64'(sb.size()), 64'(0));
      tick(2);
      check("t4_err_sticky", 64'(timeout_err), 64'(1));
      sb.push_back({6'd0, 12'h123});
      start_scan(40'h1, 8'd0, 2'd0);
      check("t4_err_cleared", 64'(timeout_err), 64'(0));
      wait_done(200, n);

      // average of eight full-scale samples
      samples = '{12'hFFF};
      s0 = soc_cnt; r0 = res_cnt;
      sb.push_back({6'd7, 12'hFFF});
      sb.push_back({6'd8, 12'hFFF});
      start_scan(40'h180, 8'd1, 2'd3);
      wait_done(1000, n);
      check("t6_soc_count", 64'(soc_cnt - s0), 64'(16));
      check("t6_res_count", 64'(res_cnt - r0), 64'(2));
      check("t6_sb_empty", 64'(sb.size()), 64'(0));

      // stray start during settle, then reset inside WAIT_EOC
      samples = '{12'h055};
      lat = 30;
      start_scan(40'h400, 8'd20, 2'd0);
      n = 0;
      while (mon_vin_sel == '0 && n < 50) begin tick(1); n++; end
      scan_start = 1'b1;
      scan_mask  = '1;
      tick(1);
      scan_start = 1'b0;
      tick(2);
      check("t5_sel_held", 64'(mon_vin_sel), 64'(40'h400));
      check("t5_busy_held", 64'(scan_busy), 64'(1));
      wait_soc(100);
      tick(5);
      #2 rst_b = 1'b0;
      #1 check("t5_async_reset", 64'(outs), 64'(0));
      tick(3);
      rst_b = 1'b1;
      s0 = soc_cnt; r0 = res_cnt; d0 = done_cnt;
      tick(120);
      check("t5_no_done", 64'(done_cnt - d0), 64'(0));
      check("t5_no_res", 64'(res_cnt - r0), 64'(0));
      check("t5_no_soc", 64'(soc_cnt - s0), 64'(0));
      check("t5_idle_outputs", 64'(outs), 64'(0));
      check("sb_final_empty", 64'(sb.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
